// File: rtl/dec_alu_issue_pkg.sv
// Shared decode constants for the ALU issue stage: ALU op codes (also used
// by the execute-stage ALU), RV32I opcode/funct3/funct7 values and the
// operand-A select encodings, plus the decoded control bundle.
package dec_alu_issue_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SNE  = 4'd7,
    ALU_SGE  = 4'd8,
    ALU_SGEU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [1:0] SEL_A_RS1  = 2'd0;
  localparam logic [1:0] SEL_A_PC   = 2'd1;
  localparam logic [1:0] SEL_A_ZERO = 2'd2;

  typedef struct packed {
    alu_op_e    op;
    logic [1:0] sel_a;
    logic       sel_b_imm;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_we;
    logic       is_branch;
    logic       br_on_zero;
  } dec_ctrl_t;

  // funct3 values shared by OP and OP-IMM that map onto a plain ALU op
  function automatic logic f3_is_arith(input logic [2:0] f3);
    case (f3)
      F3_ADD, F3_SLT, F3_SLTU, F3_XOR, F3_OR, F3_AND: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e f3_to_op(input logic [2:0] f3);
    case (f3)
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/dec_alu_comb.sv
// Pure combinational RV32I instruction -> ALU control decode.
// Optional macro DEC_ILLEGAL_CHK_EN adds the 'illegal' output.
module dec_alu_comb
  import dec_alu_issue_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       insn,
  output dec_ctrl_t         ctrl,
  output logic [DATA_W-1:0] imm
`ifdef DEC_ILLEGAL_CHK_EN
  ,
  output logic              illegal
`endif
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_sel;
  logic        supported;
  logic        writes;

  assign opcode = insn[6:0];
  assign funct3 = insn[14:12];
  assign funct7 = insn[31:25];

  assign imm_i = {{20{insn[31]}}, insn[31:20]};
  assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u = {insn[31:12], 12'h000};

  // Map opcode/funct fields onto ALU op, operand selects and immediate
  always_comb begin
    ctrl            = '0;
    ctrl.op         = ALU_ADD;
    ctrl.sel_a      = SEL_A_RS1;
    ctrl.rs1        = insn[19:15];
    ctrl.rs2        = insn[24:20];
    ctrl.rd         = insn[11:7];
    imm_sel         = 32'h0000_0000;
    supported       = 1'b0;
    writes          = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        if (f3_is_arith(funct3)) begin
          supported      = 1'b1;
          writes         = 1'b1;
          ctrl.op        = f3_to_op(funct3);
          ctrl.sel_b_imm = 1'b1;
          imm_sel        = imm_i;
        end else begin
          supported = 1'b0;   // shifts are not handled by this stage
        end
      end
      OPC_OP: begin
        if (funct7 == F7_BASE && f3_is_arith(funct3)) begin
          supported = 1'b1;
          writes    = 1'b1;
          ctrl.op   = f3_to_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          supported = 1'b1;
          writes    = 1'b1;
          ctrl.op   = ALU_SUB;
        end else begin
          supported = 1'b0;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        supported      = 1'b1;
        writes         = 1'b1;
        ctrl.sel_a     = (opcode == OPC_LUI) ? SEL_A_ZERO : SEL_A_PC;
        ctrl.sel_b_imm = 1'b1;
        imm_sel        = imm_u;
      end
      OPC_BRANCH: begin
        supported = 1'b1;
        imm_sel   = imm_b;
        case (funct3)
          F3_BEQ: begin
            ctrl.op         = ALU_SUB;
            ctrl.br_on_zero = 1'b1;
          end
          F3_BNE:  ctrl.op = ALU_SNE;
          F3_BLT:  ctrl.op = ALU_SLT;
          F3_BGE:  ctrl.op = ALU_SGE;
          F3_BLTU: ctrl.op = ALU_SLTU;
          F3_BGEU: ctrl.op = ALU_SGEU;
          default: begin
            supported = 1'b0;
            imm_sel   = 32'h0000_0000;
          end
        endcase
        ctrl.is_branch = supported;
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            supported      = 1'b1;
            writes         = 1'b1;
            ctrl.sel_b_imm = 1'b1;
            imm_sel        = imm_i;
          end
          default: supported = 1'b0;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'b000, 3'b001, 3'b010: begin
            supported      = 1'b1;
            ctrl.sel_b_imm = 1'b1;
            imm_sel        = imm_s;
          end
          default: supported = 1'b0;
        endcase
      end
      default: supported = 1'b0;
    endcase
    // x0 is never written, and anything unsupported degrades to a no-op
    ctrl.rd_we = supported && writes && (ctrl.rd != 5'd0);
    imm        = DATA_W'($signed(imm_sel));
  end

`ifdef DEC_ILLEGAL_CHK_EN
  assign illegal = ~supported;
`endif

endmodule

// File: rtl/dec_alu_issue.sv
// Decode/issue stage: registered pipeline slot with valid/ready flow
// control and flush, feeding the execute-stage ALU.
// Optional macro DEC_ILLEGAL_CHK_EN adds the registered out_illegal port.
module dec_alu_issue
  import dec_alu_issue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_insn,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_op,
  output logic [1:0]          out_sel_a,
  output logic                out_sel_b_imm,
  output logic [DATA_W-1:0]   out_imm,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_rd_we,
  output logic                out_is_branch,
  output logic                out_br_on_zero,
  output logic [PC_W-1:0]     out_pc
`ifdef DEC_ILLEGAL_CHK_EN
  ,
  output logic                out_illegal
`endif
);

  dec_ctrl_t         dec_ctrl;
  logic [DATA_W-1:0] dec_imm;
  logic              accept;
`ifdef DEC_ILLEGAL_CHK_EN
  logic              dec_illegal;
`endif

  dec_alu_comb #(.DATA_W(DATA_W)) u_comb (
    .insn    (in_insn),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm)
`ifdef DEC_ILLEGAL_CHK_EN
    ,
    .illegal (dec_illegal)
`endif
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Pipeline slot: load on accept, drop on drain or flush, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_op         <= ALU_ADD;
      out_sel_a      <= SEL_A_RS1;
      out_sel_b_imm  <= 1'b0;
      out_imm        <= {DATA_W{1'b0}};
      out_rs1        <= 5'd0;
      out_rs2        <= 5'd0;
      out_rd         <= 5'd0;
      out_rd_we      <= 1'b0;
      out_is_branch  <= 1'b0;
      out_br_on_zero <= 1'b0;
      out_pc         <= {PC_W{1'b0}};
`ifdef DEC_ILLEGAL_CHK_EN
      out_illegal    <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_op         <= dec_ctrl.op;
      out_sel_a      <= dec_ctrl.sel_a;
      out_sel_b_imm  <= dec_ctrl.sel_b_imm;
      out_imm        <= dec_imm;
      out_rs1        <= dec_ctrl.rs1;
      out_rs2        <= dec_ctrl.rs2;
      out_rd         <= dec_ctrl.rd;
      out_rd_we      <= dec_ctrl.rd_we;
      out_is_branch  <= dec_ctrl.is_branch;
      out_br_on_zero <= dec_ctrl.br_on_zero;
      out_pc         <= in_pc;
`ifdef DEC_ILLEGAL_CHK_EN
      out_illegal    <= dec_illegal;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_dec_alu_issue.sv
// Self-checking bench for dec_alu_issue using a scoreboard queue.
// Build with +define+DEC_ILLEGAL_CHK_EN to cover the illegal-instruction flag.
module tb_dec_alu_issue;
  import dec_alu_issue_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  sel_a;
    logic        sel_b_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_branch;
    logic        br_on_zero;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [1:0]  out_sel_a;
  logic        out_sel_b_imm;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_is_branch;
  logic        out_br_on_zero;
  logic [31:0] out_pc;
`ifdef DEC_ILLEGAL_CHK_EN
  logic        out_illegal;
`endif

  int   vectors;
  int   miscompares;
  exp_t q[$];
  exp_t cur_exp;
  logic [31:0] pc_n;

  dec_alu_issue #(.DATA_W(32), .PC_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_insn        (in_insn),
    .in_pc          (in_pc),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_op         (out_op),
    .out_sel_a      (out_sel_a),
    .out_sel_b_imm  (out_sel_b_imm),
    .out_imm        (out_imm),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_rd         (out_rd),
    .out_rd_we      (out_rd_we),
    .out_is_branch  (out_is_branch),
    .out_br_on_zero (out_br_on_zero),
    .out_pc         (out_pc)
`ifdef DEC_ILLEGAL_CHK_EN
    ,
    .out_illegal    (out_illegal)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic exp_t mk(input logic [31:0] insn, input logic [3:0] op, input logic [1:0] sa,
      input logic sb, input logic [31:0] imm, input logic we, input logic br, input logic boz,
      input logic ill, input logic [31:0] pc);
    exp_t e;
    e.op = op; e.sel_a = sa; e.sel_b_imm = sb; e.imm = imm;
    e.rs1 = insn[19:15]; e.rs2 = insn[24:20]; e.rd = insn[11:7];
    e.rd_we = we; e.is_branch = br; e.br_on_zero = boz; e.illegal = ill; e.pc = pc;
    return e;
  endfunction

  // Scoreboard: pop on output handshake, push on accepted input, clear on flush/reset
  always @(negedge clk) begin
    exp_t e;
    exp_t act;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out got out_valid=1 but scoreboard empty at %0t", $time);
        end else begin
          e = q.pop_front();
          act = {out_op, out_sel_a, out_sel_b_imm, out_imm, out_rs1, out_rs2, out_rd,
                 out_rd_we, out_is_branch, out_br_on_zero, 1'b0, out_pc};
`ifdef DEC_ILLEGAL_CHK_EN
          act.illegal = out_illegal;
`else
          e.illegal = 1'b0;
`endif
          if (act !== e) begin
            miscompares++;
            $display("FAIL slot_decode pc=%h got %h want %h", e.pc, act, e);
          end
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  task automatic issue(input logic [31:0] insn, input exp_t e);
    int n;
    in_insn = insn; in_pc = e.pc; cur_exp = e; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout in_ready got 0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pc_n = pc_n + 32'd4;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_timeout queue=%0d out_valid=%b want 0/0", q.size(), out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_insn = 32'h0; in_pc = 32'h0;
    flush = 1'b0; out_ready = 1'b0; pc_n = 32'h0000_0100;
    #12;
    vectors++;
    if (out_valid !== 1'b0 || out_op !== ALU_ADD || out_imm !== 32'h0 || out_pc !== 32'h0 ||
        out_rd_we !== 1'b0 || out_is_branch !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state valid=%b op=%h imm=%h pc=%h we=%b br=%b rdy=%b want 0/0/0/0/0/0/1",
               out_valid, out_op, out_imm, out_pc, out_rd_we, out_is_branch, in_ready);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    logic [31:0] w;
    out_ready = 1'b0;
    w = enc_r(7'h20, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011);
    issue(w, mk(w, ALU_SUB, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    #2;
    vectors++;
    if (out_valid !== 1'b1 || out_op !== ALU_SUB) begin
      miscompares++;
      $display("FAIL midreset_loaded valid=%b op=%h want 1/%h", out_valid, out_op, ALU_SUB);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_op !== ALU_ADD || out_rd_we !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async valid=%b op=%h we=%b want 0/%h/0", out_valid, out_op, out_rd_we, ALU_ADD);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic test_addi();
    issue(32'hFFD08293, mk(32'hFFD08293, ALU_ADD, 2'd0, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_op !== ALU_ADD || out_sel_b_imm !== 1'b1 ||
        out_imm !== 32'hFFFF_FFFD || out_rd !== 5'd5 || out_rd_we !== 1'b1) begin
      miscompares++;
      $display("FAIL addi_latency valid=%b op=%h sbi=%b imm=%h rd=%0d we=%b want 1/0/1/fffffffd/5/1",
               out_valid, out_op, out_sel_b_imm, out_imm, out_rd, out_rd_we);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_alu_ops();
    logic [31:0] w;
    w = enc_i(12'h7FF, 5'd2, 3'b100, 5'd6, 7'b0010011);
    issue(w, mk(w, ALU_XOR, 2'd0, 1'b1, 32'h0000_07FF, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_i(12'h800, 5'd3, 3'b110, 5'd7, 7'b0010011);
    issue(w, mk(w, ALU_OR, 2'd0, 1'b1, 32'hFFFF_F800, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_i(12'h0F0, 5'd4, 3'b111, 5'd8, 7'b0010011);
    issue(w, mk(w, ALU_AND, 2'd0, 1'b1, 32'h0000_00F0, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_i(12'hFFF, 5'd5, 3'b010, 5'd9, 7'b0010011);
    issue(w, mk(w, ALU_SLT, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_i(12'h001, 5'd6, 3'b011, 5'd10, 7'b0010011);
    issue(w, mk(w, ALU_SLTU, 2'd0, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_r(7'h00, 5'd13, 5'd12, 3'b000, 5'd11, 7'b0110011);
    issue(w, mk(w, ALU_ADD, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_r(7'h20, 5'd16, 5'd15, 3'b000, 5'd14, 7'b0110011);
    issue(w, mk(w, ALU_SUB, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_r(7'h00, 5'd19, 5'd18, 3'b010, 5'd17, 7'b0110011);
    issue(w, mk(w, ALU_SLT, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_r(7'h00, 5'd22, 5'd21, 3'b011, 5'd20, 7'b0110011);
    issue(w, mk(w, ALU_SLTU, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_r(7'h00, 5'd3, 5'd2, 3'b111, 5'd1, 7'b0110011);
    issue(w, mk(w, ALU_AND, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_u(20'hABCDE, 5'd23, 7'b0110111);
    issue(w, mk(w, ALU_ADD, 2'd2, 1'b1, 32'hABCD_E000, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_u(20'h80000, 5'd24, 7'b0010111);
    issue(w, mk(w, ALU_ADD, 2'd1, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_i(12'hFFC, 5'd26, 3'b010, 5'd25, 7'b0000011);
    issue(w, mk(w, ALU_ADD, 2'd0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, pc_n));
    w = enc_s(12'hFF8, 5'd27, 5'd28, 3'b010);
    issue(w, mk(w, ALU_ADD, 2'd0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0, pc_n));
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    w = enc_b(13'h0010, 5'd2, 5'd1, 3'b000);
    issue(w, mk(w, ALU_SUB, 2'd0, 1'b0, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 1'b0, pc_n));
    w = enc_b(13'h1FF8, 5'd4, 5'd3, 3'b111);
    issue(w, mk(w, ALU_SGEU, 2'd0, 1'b0, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 1'b0, pc_n));
    w = enc_b(13'h0FFE, 5'd6, 5'd5, 3'b001);
    issue(w, mk(w, ALU_SNE, 2'd0, 1'b0, 32'h0000_0FFE, 1'b0, 1'b1, 1'b0, 1'b0, pc_n));
    w = enc_b(13'h1000, 5'd8, 5'd7, 3'b100);
    issue(w, mk(w, ALU_SLT, 2'd0, 1'b0, 32'hFFFF_F000, 1'b0, 1'b1, 1'b0, 1'b0, pc_n));
    w = enc_b(13'h0800, 5'd10, 5'd9, 3'b101);
    issue(w, mk(w, ALU_SGE, 2'd0, 1'b0, 32'h0000_0800, 1'b0, 1'b1, 1'b0, 1'b0, pc_n));
    w = enc_b(13'h0002, 5'd12, 5'd11, 3'b110);
    issue(w, mk(w, ALU_SLTU, 2'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 1'b0, pc_n));
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] wa;
    logic [31:0] wb;
    exp_t ea;
    out_ready = 1'b0;
    wa = enc_i(12'h123, 5'd1, 3'b000, 5'd2, 7'b0010011);
    ea = mk(wa, ALU_ADD, 2'd0, 1'b1, 32'h0000_0123, 1'b1, 1'b0, 1'b0, 1'b0, pc_n);
    issue(wa, ea);
    wb = enc_i(12'h456, 5'd3, 3'b100, 5'd4, 7'b0010011);
    in_insn = wb; in_pc = pc_n;
    cur_exp = mk(wb, ALU_XOR, 2'd0, 1'b1, 32'h0000_0456, 1'b1, 1'b0, 1'b0, 1'b0, pc_n);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op !== ea.op || out_imm !== ea.imm ||
          out_rd !== ea.rd || out_pc !== ea.pc) begin
        miscompares++;
        $display("FAIL backpressure_hold cyc=%0d rdy=%b valid=%b op=%h imm=%h rd=%0d pc=%h want 0/1/%h/%h/%0d/%h",
                 i, in_ready, out_valid, out_op, out_imm, out_rd, out_pc, ea.op, ea.imm, ea.rd, ea.pc);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pc_n = pc_n + 32'd4;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_op !== ALU_XOR || out_imm !== 32'h0000_0456) begin
      miscompares++;
      $display("FAIL reload_on_drain valid=%b op=%h imm=%h want 1/%h/00000456", out_valid, out_op, out_imm, ALU_XOR);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_flush();
    logic [31:0] w;
    out_ready = 1'b1;
    w = enc_i(12'h055, 5'd1, 3'b000, 5'd9, 7'b0010011);
    in_insn = w; in_pc = pc_n; in_valid = 1'b1; flush = 1'b1;
    cur_exp = mk(w, ALU_ADD, 2'd0, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0, pc_n);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_discard out_valid got %b want 0", out_valid);
    end
    @(posedge clk); #1;
    w = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0110011);
    issue(w, mk(w, ALU_ADD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, pc_n));
    wait_drain();
  endtask

  task automatic test_unsupported();
    logic [31:0] w;
    w = 32'h00109093;
    issue(w, mk(w, ALU_ADD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, pc_n));
    @(negedge clk);
    vectors++;
`ifdef DEC_ILLEGAL_CHK_EN
    if (out_valid !== 1'b1 || out_rd_we !== 1'b0 || out_illegal !== 1'b1) begin
      miscompares++;
      $display("FAIL slli_illegal valid=%b we=%b illegal=%b want 1/0/1", out_valid, out_rd_we, out_illegal);
    end
`else
    if (out_valid !== 1'b1 || out_rd_we !== 1'b0 || out_op !== ALU_ADD) begin
      miscompares++;
      $display("FAIL slli_noop valid=%b we=%b op=%h want 1/0/%h", out_valid, out_rd_we, out_op, ALU_ADD);
    end
`endif
    @(posedge clk); #1;
    w = 32'h000000EF;
    issue(w, mk(w, ALU_ADD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, pc_n));
    w = 32'hFFF08290;
    issue(w, mk(w, ALU_ADD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, pc_n));
    w = enc_r(7'h20, 5'd3, 5'd2, 3'b100, 5'd1, 7'b0110011);
    issue(w, mk(w, ALU_ADD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, pc_n));
    w = enc_b(13'h0010, 5'd2, 5'd1, 3'b010);
    issue(w, mk(w, ALU_ADD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, pc_n));
    wait_drain();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_reset_midstream();
    test_addi();
    test_alu_ops();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_unsupported();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_scoreboard entries=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
